// File: rtl/rv_mem_arb.sv
// Single-port memory arbiter: data-first fixed priority with a starvation guard
// for instruction fetch; registers the winner onto the memory port until ack.
module rv_mem_arb #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned STARVE = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req_i,
    input  logic [AW-1:0]   if_addr_i,
    output logic            if_ack_o,
    output logic [DW-1:0]   if_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [DW/8-1:0] d_be_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    output logic            d_ack_o,
    output logic [DW-1:0]   d_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            busy_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = $clog2(STARVE + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GNT_IF = 2'd1;
    localparam logic [1:0] GNT_D  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          d_win;
    logic          mem_req_nxt, mem_we_nxt;
    logic [BW-1:0] mem_be_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic          if_ack_nxt, d_ack_nxt, busy_nxt;
    logic [DW-1:0] if_rdata_nxt, d_rdata_nxt;

    // Next-state and next-output logic; every register holds unless updated.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        mem_req_nxt   = mem_req_o;
        mem_we_nxt    = mem_we_o;
        mem_be_nxt    = mem_be_o;
        mem_addr_nxt  = mem_addr_o;
        mem_wdata_nxt = mem_wdata_o;
        if_rdata_nxt  = if_rdata_o;
        d_rdata_nxt   = d_rdata_o;
        if_ack_nxt    = 1'b0;
        d_ack_nxt     = 1'b0;
        // Data yields to a waiting fetch once it has won STARVE times in a row.
        d_win         = d_req_i && (!if_req_i || (cnt < CW'(STARVE)));

        case (state)
            IDLE: begin
                if (d_win) begin
                    state_nxt     = GNT_D;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = d_we_i;
                    mem_be_nxt    = d_be_i;
                    mem_addr_nxt  = d_addr_i;
                    mem_wdata_nxt = d_wdata_i;
                    if (if_req_i) begin
                        cnt_nxt = (cnt == CW'(STARVE)) ? cnt : cnt + CW'(1);
                    end else begin
                        cnt_nxt = '0;
                    end
                end else if (if_req_i) begin
                    state_nxt     = GNT_IF;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_be_nxt    = '1;
                    mem_addr_nxt  = if_addr_i;
                    mem_wdata_nxt = '0;
                    cnt_nxt       = '0;
                end
            end
            GNT_IF: begin
                if (mem_ack_i) begin
                    state_nxt    = RESP;
                    mem_req_nxt  = 1'b0;
                    if_ack_nxt   = 1'b1;
                    if_rdata_nxt = mem_rdata_i;
                end
            end
            GNT_D: begin
                if (mem_ack_i) begin
                    state_nxt   = RESP;
                    mem_req_nxt = 1'b0;
                    d_ack_nxt   = 1'b1;
                    if (!mem_we_o) begin
                        d_rdata_nxt = mem_rdata_i;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            d_ack_o     <= 1'b0;
            if_rdata_o  <= '0;
            d_rdata_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mem_req_o   <= mem_req_nxt;
            mem_we_o    <= mem_we_nxt;
            mem_be_o    <= mem_be_nxt;
            mem_addr_o  <= mem_addr_nxt;
            mem_wdata_o <= mem_wdata_nxt;
            if_ack_o    <= if_ack_nxt;
            d_ack_o     <= d_ack_nxt;
            if_rdata_o  <= if_rdata_nxt;
            d_rdata_o   <= d_rdata_nxt;
            busy_o      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Randomized scoreboard bench for rv_mem_arb: grant choice, memory payload,
// ack routing, read-data capture, starvation pattern and reset behaviour.
module tb_rv_mem_arb;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned STARVE = 4;
    localparam int unsigned BW     = DW / 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          if_req_i, if_ack_o, d_req_i, d_we_i, d_ack_o;
    logic          mem_req_o, mem_we_o, mem_ack_i, busy_o;
    logic [AW-1:0] if_addr_i, d_addr_i, mem_addr_o;
    logic [DW-1:0] if_rdata_o, d_wdata_i, d_rdata_o, mem_wdata_o, mem_rdata_i;
    logic [BW-1:0] d_be_i, mem_be_o;

    rv_mem_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .rstn(rstn),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_d;
        logic          is_load;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    bit   gseq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Stimulus knobs, written only by the main sequence.
    bit gen_if = 0, gen_d = 0, spur_en = 0, tie_ack = 0, mem_hold = 0, force_load = 0;
    bit starv = 0, b2b = 0;
    int p_req = 0, max_wait = 0;

    // Reference model state.
    logic          snap_if = 0, snap_d = 0, prev_req = 0, prev_busy = 0;
    int            m_cnt = 0, cyc = 0, last_d_ack = -1, n_d_ack = 0, n_b2b = 0;
    logic [DW-1:0] m_if_rdata = '0, m_d_rdata = '0;
    logic          g_is_d = 0, g_we = 0;
    logic [BW-1:0] g_be = '0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wdata = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {if_ack_o, d_ack_o, mem_req_o, mem_we_o, busy_o, mem_be_o}, '0);
        check({tag, "_mem"}, {mem_addr_o, mem_wdata_o}, '0);
        check({tag, "_rdata"}, {if_rdata_o, d_rdata_o}, '0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        gen_if = 0;
        gen_d  = 0;
        @(negedge clk);
        while ((if_req_i || d_req_i || busy_o) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_done", (t < 200), 1'b1);
    endtask

    // Fetch requester: holds request and address until its ack.
    initial begin
        if_req_i  = 0;
        if_addr_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (if_req_i && if_ack_o) if_req_i = 0;
            if (!if_req_i && gen_if && rstn && $urandom_range(99) < p_req) begin
                if_req_i  = 1;
                if_addr_i = AW'($urandom) & ~AW'(3);
            end
        end
    end

    // Load/store requester.
    initial begin
        d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (d_req_i && d_ack_o) d_req_i = 0;
            if (!d_req_i && gen_d && rstn && $urandom_range(99) < p_req) begin
                d_req_i   = 1;
                d_we_i    = force_load ? 1'b0 : 1'($urandom_range(1));
                d_be_i    = BW'($urandom);
                d_addr_i  = AW'($urandom);
                d_wdata_i = DW'($urandom);
            end
        end
    end

    // Memory: random wait states, random read data every cycle, optional stray acks.
    initial begin
        mem_ack_i = 0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata_i = DW'($urandom);
            if (tie_ack) mem_ack_i = 1;
            else if (mem_req_o) mem_ack_i = !mem_hold && ($urandom_range(max_wait) == 0);
            else mem_ack_i = spur_en && ($urandom_range(3) == 0);
        end
    end

    // Request snapshot and expected-response push at the sampling edge.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        snap_if <= if_req_i;
        snap_d  <= d_req_i;
        if (rstn && mem_req_o && mem_ack_i)
            exp_q.push_back('{is_d: g_is_d, is_load: !g_we, rdata: mem_rdata_i});
    end

    // Monitor: predicts grants, checks the memory port, pops acks.
    always @(negedge clk) begin
        exp_t e;
        logic got_g, exp_g, dw;
        if (!rstn) begin
            exp_q.delete();
            m_cnt = 0; m_if_rdata = '0; m_d_rdata = '0;
            prev_req = 0; prev_busy = 0; last_d_ack = -1;
        end else begin
            got_g = mem_req_o && !prev_req;
            exp_g = !prev_busy && (snap_if || snap_d);
            check("grant_issue", got_g, exp_g);
            if (got_g && exp_g) begin
                dw = snap_d && (!snap_if || m_cnt < STARVE);
                g_is_d = dw;
                if (dw) begin
                    g_we = d_we_i; g_be = d_be_i; g_addr = d_addr_i; g_wdata = d_wdata_i;
                    m_cnt = snap_if ? ((m_cnt < STARVE) ? m_cnt + 1 : m_cnt) : 0;
                end else begin
                    g_we = 0; g_be = '1; g_addr = if_addr_i; g_wdata = '0;
                    m_cnt = 0;
                end
                if (starv) gseq.push_back(dw);
            end
            if (mem_req_o) begin
                check("mem_ctrl", {mem_we_o, mem_be_o}, {g_we, g_be});
                check("mem_addr", mem_addr_o, g_addr);
                check("mem_wdata", mem_wdata_o, g_wdata);
            end
            if (if_ack_o || d_ack_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_ack", {if_ack_o, d_ack_o}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_sel", {if_ack_o, d_ack_o}, e.is_d ? 2'b01 : 2'b10);
                    if (!e.is_d) m_if_rdata = e.rdata;
                    else if (e.is_load) m_d_rdata = e.rdata;
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ack_missing", 2'b00, e.is_d ? 2'b01 : 2'b10);
            end
            if (d_ack_o) begin
                n_d_ack++;
                if (b2b) begin
                    n_b2b++;
                    if (last_d_ack >= 0) check("b2b_gap", cyc - last_d_ack, 3);
                end
                last_d_ack = cyc;
            end
            if (!b2b) last_d_ack = -1;
            check("if_rdata", if_rdata_o, m_if_rdata);
            check("d_rdata", d_rdata_o, m_d_rdata);
            check("busy", busy_o, mem_req_o || if_ack_o || d_ack_o);
            prev_req  = mem_req_o;
            prev_busy = busy_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int last_if, nif, base;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        #2 rstn = 1;

        // Mixed random traffic with wait states and stray acks.
        gen_if = 1; gen_d = 1; p_req = 40; max_wait = 3; spur_en = 1;
        repeat (1500) @(negedge clk);
        drain();

        // Both requesters saturated, zero-wait memory: D x STARVE then IF.
        spur_en = 0; max_wait = 0; p_req = 100; starv = 1;
        gen_if = 1; gen_d = 1;
        repeat (300) @(negedge clk);
        starv = 0;
        drain();
        last_if = -1;
        nif = 0;
        foreach (gseq[i]) begin
            if (!gseq[i]) begin
                if (last_if >= 0) check("starve_run", i - last_if - 1, STARVE);
                last_if = i;
                nif++;
            end
        end
        check("starve_if_grants", (nif >= 3), 1'b1);

        // Loads only with the memory ack tied high.
        force_load = 1; tie_ack = 1; b2b = 1; gen_d = 1;
        repeat (60) @(negedge clk);
        b2b = 0;
        drain();
        tie_ack = 0; force_load = 0;
        check("b2b_count", (n_b2b >= 15), 1'b1);

        // Reset while a data transaction waits on the memory.
        mem_hold = 1; gen_d = 1;
        base = 0;
        while (!mem_req_o && base < 20) begin
            @(negedge clk);
            base++;
        end
        gen_d = 0;
        check("rst_setup_req", {mem_req_o, d_req_i}, 2'b11);
        #2 rstn = 0;
        #1 check_reset_outputs("mid_rst");
        base = n_d_ack;
        @(negedge clk);
        #2 rstn = 1;
        mem_hold = 0;
        drain();
        check("rst_regrant_acks", n_d_ack - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
